// File: rtl/button_bank.sv
// Multi-channel push-button front end: sync, debounce, press/release pulses,
// long-press detection with optional auto-repeat. "rel" is the release pulse (release is reserved).
module button_bank_chan #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int HOLD_CYCLES     = 50000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int IN_ACTIVE_LOW   = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic out_next,
    output logic out,
    output logic press,
    output logic rel,
    output logic hold
);
    localparam int   HMAX   = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int   HW     = $clog2(HMAX + 1);
    localparam int   DW     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int   RPT_M1 = (REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0;
    localparam logic POL    = (IN_ACTIVE_LOW != 0);

    typedef enum logic [1:0] {RELEASED, PRESSED, HELD} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic [DW-1:0]          dcnt;
    logic [HW-1:0]          hcnt;
    logic                   s;
    logic                   flip;

    assign s        = sync[SYNC_STAGES-1] ^ POL;
    assign flip     = (s != out) && (dcnt == DW'(DEBOUNCE_CYCLES - 1));
    assign out_next = flip ? ~out : out;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync  <= '0;
            dcnt  <= '0;
            hcnt  <= '0;
            out   <= 1'b0;
            press <= 1'b0;
            rel   <= 1'b0;
            hold  <= 1'b0;
            state <= RELEASED;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], in};
            dcnt  <= (s == out || flip) ? '0 : dcnt + 1'b1;
            out   <= out_next;
            press <= 1'b0;
            rel   <= 1'b0;
            hold  <= 1'b0;
            case (state)
                RELEASED: begin
                    if (flip) begin
                        state <= PRESSED;
                        press <= 1'b1;
                        hcnt  <= '0;
                    end
                end
                PRESSED: begin
                    if (flip) begin
                        state <= RELEASED;
                        rel   <= 1'b1;
                        hcnt  <= '0;
                    end else if (hcnt == HW'(HOLD_CYCLES - 1)) begin
                        state <= HELD;
                        hold  <= 1'b1;
                        // without repeat the counter parks at HOLD_CYCLES
                        hcnt  <= (REPEAT_CYCLES > 0) ? '0 : HW'(HOLD_CYCLES);
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
                end
                HELD: begin
                    if (flip) begin
                        state <= RELEASED;
                        rel   <= 1'b1;
                        hcnt  <= '0;
                    end else if (REPEAT_CYCLES > 0) begin
                        if (hcnt == HW'(RPT_M1)) begin
                            hold <= 1'b1;
                            hcnt <= '0;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
                end
                default: state <= RELEASED;
            endcase
        end
    end
endmodule

module button_bank #(
    parameter int CHANNELS        = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 64,
    parameter int HOLD_CYCLES     = 50000,
    parameter int REPEAT_CYCLES   = 0,
    parameter int IN_ACTIVE_LOW   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] press,
    output logic [CHANNELS-1:0] rel,
    output logic [CHANNELS-1:0] hold,
    output logic                any_pressed
);
    logic [CHANNELS-1:0] out_next;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        button_bank_chan #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .REPEAT_CYCLES  (REPEAT_CYCLES),
            .IN_ACTIVE_LOW  (IN_ACTIVE_LOW)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .in      (in[i]),
            .out_next(out_next[i]),
            .out     (out[i]),
            .press   (press[i]),
            .rel     (rel[i]),
            .hold    (hold[i])
        );
    end

    // registered from next-state so it lines up with out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) any_pressed <= 1'b0;
        else      any_pressed <= |out_next;
    end
endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
Parametrised multi-channel successor to the single-input button debouncer. Each channel does the following:
- synchronises a raw mechanical input;
- debounces it with a programmable stability window;
- emits single-cycle press/release pulses;
- detects long-press with optional auto-repeat.

Sits between board push-buttons/switches and the control FSMs; replaces per-button debouncer instances.

Parameters:
CHANNELS, 4, number of independent input channels (1..32)
SYNC_STAGES, 2, flip-flops in each input synchroniser (>=2)
DEBOUNCE_CYCLES, 64, consecutive stable cycles required before the debounced level changes (>=1)
HOLD_CYCLES, 50000, cycles out must stay high after rising before the first hold pulse (>=1)
REPEAT_CYCLES, 0, period of repeat hold pulses after the first; 0 disables repeat
IN_ACTIVE_LOW, 0, 1 = raw inputs are active-low (inverted after the synchroniser)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
in  input  CHANNELS  raw asynchronous button inputs
out  output  CHANNELS  debounced level per channel (1 = pressed)
press  output  CHANNELS  1-cycle pulse in the cycle out first reads 1
release  output  CHANNELS  1-cycle pulse in the cycle out first reads 0
hold  output  CHANNELS  1-cycle long-press / repeat pulse
any_pressed  output  1  OR of out

Behaviour:
- Reset: rst=0 asynchronously clears all state immediately.
  - out, press, release, hold, any_pressed = 0.
  - Synchroniser flops, debounce counters and hold counters = 0.
  - Channel state = RELEASED.
- Reset mid-press: a held input re-qualifies from scratch after rst deasserts. There is no press pulse during reset.
- Synchroniser: per channel. Polarity inversion is applied after the last stage when IN_ACTIVE_LOW=1. The result is s[i].
- Debounce counter: width $clog2(DEBOUNCE_CYCLES+1).
  - Cleared whenever s[i]==out[i].
  - Incremented each cycle s[i]!=out[i].
  - On the edge where the count would reach DEBOUNCE_CYCLES: out[i] toggles and the counter clears.
- Latency: a clean input step reaches out after SYNC_STAGES+DEBOUNCE_CYCLES rising edges.
- Glitch rejection: any mismatch run shorter than DEBOUNCE_CYCLES produces no output change and no pulses.
- Per-channel FSM states:
  - RELEASED: out=0. Qualified rise -> PRESSED; press=1 that cycle.
  - PRESSED: out=1. The hold counter counts from 0 starting in the first cycle out=1.
    - On reaching HOLD_CYCLES -> HELD; hold=1 that cycle.
    - Qualified fall -> RELEASED; release=1.
  - HELD: out=1.
    - If REPEAT_CYCLES>0: hold=1 every REPEAT_CYCLES cycles after the first hold pulse.
    - Qualified fall -> RELEASED; release=1; hold counter cleared.
- Hold counter: width $clog2(max(HOLD_CYCLES,REPEAT_CYCLES)+1). It never wraps; in HELD with REPEAT_CYCLES=0 it saturates.
- Fall coincident with a hold/repeat instant: release wins and hold stays 0.
- press, release and hold are mutually exclusive per channel per cycle.
- Channels are fully independent. Simultaneous events on different channels all pulse in the same cycle.
- any_pressed is a registered OR of the next out values, so it is cycle-aligned with out.
- All outputs are registered; there are no combinational paths from in.

Test Plan:
Unless stated otherwise: CHANNELS=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, HOLD_CYCLES=16, REPEAT_CYCLES=8, 20 ns clock.

1. Reset: hold rst=0 with in=2'b11 for 5 cycles -> all outputs 0. After release, out[1:0]=2'b11 after exactly 6 edges, with press=2'b11 for one cycle and release=0.
2. Clean press/release on ch0: in[0] high for 40 cycles then low.
   - out[0] rises on edge 6; press[0] pulses once.
   - hold[0] pulses at 16 cycles after out rose, then at +8 and +16.
   - out[0] falls 6 edges after in falls; release[0] pulses once; out[1] stays 0.
3. Glitch rejection: in[0] bounces high 3 cycles / low 1 cycle repeatedly for 60 cycles, then returns low -> out[0] never changes, no pulses.
4. Long press, no repeat: rebuild with REPEAT_CYCLES=0 and hold in[0] high 100 cycles -> exactly one hold pulse, 16 cycles after out rose.
5. Simultaneous channels: in=2'b11 in the same cycle -> press=2'b11 in the same cycle. Then release ch1 only -> release=2'b10 and any_pressed stays 1.
6. Release/repeat collision: drop in[0] so the qualified fall lands on a repeat instant -> release[0]=1 and hold[0]=0 in that cycle. Also assert rst=0 mid-HELD -> outputs clear asynchronously, with no release pulse.
